// File: rtl/md_alu_sequencer.sv
// ---------------------------------------------------------------------------
// md_alu_sequencer
//   Iterative multiply/divide controller for the E-stage. Runs MULTU/DIVU
//   (and MULT/DIV when SIGNED_MD_EN is defined) one step per cycle through
//   the shared 32-bit ALU, and handles MTHI/MTLO. HI/LO live here.
//
//   Optional feature macro: SIGNED_MD_EN
//     defined   : md_op 100/101 are signed MULT/DIV. Operands are converted
//                 to magnitudes at start. A FIX cycle then applies the signs
//                 (33 busy cycles).
//     undefined : md_op 100/101 run as MULTU/DIVU (32 busy cycles). There is
//                 no FIX state.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; clears all state
//   start      in   single-cycle request, sampled only while idle
//   md_op[2:0] in   000 MULTU, 001 DIVU, 010 MTHI, 011 MTLO, 100 MULT, 101 DIV
//   rs[31:0]   in   dividend / multiplicand / MTHI-MTLO data
//   rt[31:0]   in   divisor / multiplier
//   busy       out  high while a mul/div is in progress
//   hi, lo     out  HI/LO registers (intermediate values while busy)
//   alu_a/b    out  ALU operands; zero when no step is running
//   alu_op     out  0000 = A+B, 0001 = A-B
//   alu_c      in   ALU result, combinational in the same cycle
//   state_dbg  out  current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
//
// Handshake: start is a request pulse with no acknowledge. The block
//   accepts it only in IDLE. busy is high from the cycle after acceptance
//   until the last step has been written. hi/lo are valid once busy is low.
// ---------------------------------------------------------------------------
module md_alu_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic [1:0]  state_dbg
);

`ifdef SIGNED_MD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`endif

  state_t      state, state_nx;
  logic [5:0]  counter;
  logic [31:0] opb;          // multiplicand (MUL) or divisor (DIV)

  logic        idle, last_step;
  logic        go_mul, go_div, go_mthi, go_mtlo;
  logic        signed_req;
  logic [31:0] rs_mag, rt_mag;
  logic [31:0] mul_sum, rem_sh;
  logic        mul_carry, div_sub;
  logic        done_to_fix;

  assign idle      = (state == S_IDLE);
  assign busy      = ~idle;
  assign state_dbg = state;
  assign last_step = (counter == 6'(ITER - 1));

  // 110/111 decode to nothing and are dropped.
  assign go_mul  = start & idle & (md_op[1:0] == 2'b00);
  assign go_div  = start & idle & (md_op[1:0] == 2'b01);
  assign go_mthi = start & idle & (md_op == 3'b010);
  assign go_mtlo = start & idle & (md_op == 3'b011);

`ifdef SIGNED_MD_EN
  logic        sgn_op, fix_div, neg_quo, neg_rem;
  logic [63:0] prod_neg;
  assign signed_req  = md_op[2];
  assign done_to_fix = sgn_op;
  assign prod_neg    = -{hi, lo};
`else
  assign signed_req  = 1'b0;
  assign done_to_fix = 1'b0;
`endif

  assign rs_mag = (signed_req & rs[31]) ? -rs : rs;
  assign rt_mag = (signed_req & rt[31]) ? -rt : rt;

  // Shift-add step: the ALU sum is only taken when the multiplier LSB is set.
  // The ALU sum wrapped exactly when it is below the old hi.
  assign mul_sum   = lo[0] ? alu_c : hi;
  assign mul_carry = lo[0] & (alu_c < hi);

  // Restoring divide step: the partial remainder shifted left with the next
  // dividend bit. A bit shifted out of rem means the true value is >= 2^32,
  // so the subtract is always taken.
  assign rem_sh  = {hi[30:0], lo[31]};
  assign div_sub = hi[31] | (rem_sh >= opb);

  // Next-state and ALU drive
  always_comb begin
    state_nx = state;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_op   = 4'b0000;
    case (state)
      S_IDLE: begin
        if (go_mul)      state_nx = S_MUL;
        else if (go_div) state_nx = S_DIV;
      end
      S_MUL: begin
        alu_a  = hi;
        alu_b  = opb;
        alu_op = 4'b0000;
        if (last_step) state_nx = done_to_fix ? state_t'(2'd3) : S_IDLE;
      end
      S_DIV: begin
        alu_a  = rem_sh;
        alu_b  = opb;
        alu_op = 4'b0001;
        if (last_step) state_nx = done_to_fix ? state_t'(2'd3) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Datapath: hi/lo double as product (MUL) and remainder/quotient (DIV)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      opb     <= 32'd0;
      counter <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_mthi) hi <= rs;
          if (go_mtlo) lo <= rs;
          if (go_mul) begin
            hi      <= 32'd0;
            lo      <= rt_mag;
            opb     <= rs_mag;
            counter <= 6'd0;
          end
          if (go_div) begin
            hi      <= 32'd0;
            lo      <= rs_mag;
            opb     <= rt_mag;
            counter <= 6'd0;
          end
        end
        S_MUL: begin
          hi      <= {mul_carry, mul_sum[31:1]};
          lo      <= {mul_sum[0], lo[31:1]};
          counter <= last_step ? 6'd0 : counter + 6'd1;
        end
        S_DIV: begin
          hi      <= div_sub ? alu_c : rem_sh;
          lo      <= {lo[30:0], div_sub};
          counter <= last_step ? 6'd0 : counter + 6'd1;
        end
`ifdef SIGNED_MD_EN
        S_FIX: begin
          if (fix_div) begin
            if (neg_quo) lo <= -lo;
            if (neg_rem) hi <= -hi;
          end else if (neg_quo) begin
            {hi, lo} <= prod_neg;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef SIGNED_MD_EN
  // Sign bookkeeping for the FIX cycle. A zero divisor leaves the raw
  // magnitude result, so both negations are suppressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgn_op  <= 1'b0;
      fix_div <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (go_mul | go_div) begin
      sgn_op  <= signed_req;
      fix_div <= go_div;
      neg_quo <= signed_req & (rs[31] ^ rt[31]) & ~(go_div & (rt == 32'd0));
      neg_rem <= signed_req & rs[31] & go_div & (rt != 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_md_alu_sequencer.sv
// Testbench for md_alu_sequencer. The ALU is modelled here as a plain
// adder/subtractor. Expected HI/LO come from constants and a 64-bit
// reference model.
module tb_md_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  md_alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .state_dbg(state_dbg)
  );

  // Shared ALU
  assign alu_c = (alu_op == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    longint      sa, sb, p, q, r;
    logic [31:0] am;
    sgn = 1'b0;
`ifdef SIGNED_MD_EN
    sgn = op[2];
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[0] == 1'b0) begin
      if (sgn) begin
        p = sa * sb;
        return p;
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) begin
      am = (sgn && a[31]) ? -a : a;
      return {am, 32'hFFFFFFFF};
    end
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int exp_busy(input logic [2:0] op);
    int n;
    n = 32;
`ifdef SIGNED_MD_EN
    if (op[2]) n = 33;
`endif
    return n;
  endfunction

  // Driver: issue a mul/div at a negedge, count busy cycles, then score.
  // poke > 0 pulses a DIVU request during that busy cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int poke);
    int cnt;
    logic [63:0] e;
    exp_q.push_back(exp);
    start = 1'b1; md_op = op; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      start = (cnt == poke);
      if (start) begin
        md_op = 3'b001;
        rs = $urandom;
        rt = $urandom_range(1, 1000);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy(op)));
    e = exp_q.pop_front();
    check({name, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; md_op = 3'd0; rs = 32'd0; rt = 32'd0;

    vecs.push_back('{"multu_max",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"divu_100_7",  3'b001, 32'd100, 32'd7, 32'd2, 32'd14});
    vecs.push_back('{"divu_by0",    3'b001, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF});
    vecs.push_back('{"multu_2p32",  3'b000, 32'h00010000, 32'h00010000, 32'd1, 32'd0});
    vecs.push_back('{"multu_zero",  3'b000, 32'd0, 32'h12345678, 32'd0, 32'd0});
    vecs.push_back('{"divu_small",  3'b001, 32'd7, 32'd100, 32'd7, 32'd0});
    vecs.push_back('{"divu_by1",    3'b001, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF});
    vecs.push_back('{"divu_msb",    3'b001, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA});
`ifdef SIGNED_MD_EN
    vecs.push_back('{"mult_m3_5",   3'b100, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"div_m7_2",    3'b101, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_m5_0",    3'b101, 32'hFFFFFFFB, 32'd0, 32'd5, 32'hFFFFFFFF});
`else
    vecs.push_back('{"mult_as_u",   3'b100, 32'hFFFFFFFD, 32'd5, 32'd4, 32'hFFFFFFF1});
    vecs.push_back('{"div_as_u",    3'b101, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC});
    vecs.push_back('{"div_as_u_0",  3'b101, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF});
`endif

    repeat (3) @(negedge clk);
    // Reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_alu", {alu_a, alu_b}, 64'd0);
    check("rst_alu_op", {60'd0, alu_op}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].ehi, vecs[i].elo}, 0);

    // Random ops against the model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 5));
      if (rop[1]) rop = {rop[2], 2'b00};
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 0);
    end

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; md_op = 3'b010; rs = 32'h1234;
    @(negedge clk);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    md_op = 3'b011; rs = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    check("mt_hi", {32'd0, hi}, 64'h1234);
    check("mt_lo", {32'd0, lo}, 64'h5678);

    // Undefined opcodes leave everything alone
    start = 1'b1; md_op = 3'b110; rs = 32'hDEAD; rt = 32'hBEEF;
    @(negedge clk);
    md_op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("undef_busy", {63'd0, busy}, 64'd0);
    check("undef_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // DIVU request while a MULTU is busy must be ignored
    run_op("poke_multu", 3'b000, 32'd123456, 32'd789, model(3'b000, 32'd123456, 32'd789), 5);

    // Reset mid-MULTU
    start = 1'b1; md_op = 3'b000; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("after_abort", 3'b001, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

    if (exp_q.size() != 0) check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
